led_pattern_counter: RTL and testbench
======================================

LED_PATTERN_COUNTER -- requirements
Module: led_pattern_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6: LED count and pattern width, legal range >= 2.
REQ-002 SHALL have parameter CLK_DIV, default 13500000: clk cycles per pattern step, legal range >= 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 270000: stable-level cycles required to accept a button change, legal range >= 1.
REQ-004 SHALL have parameter LED_ACTIVE_LOW, default 1: when 1, led bits are inverted (0 = lit).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port mode_btn, input, 1 bit: raw asynchronous button, active-low, pulled up.
REQ-008 SHALL have port pause_btn, input, 1 bit: raw asynchronous button, active-low, pulled up.
REQ-009 SHALL have port led, output, WIDTH bits: registered LED drive.
REQ-010 SHALL have port tick, output, 1 bit: registered one-cycle step strobe.
REQ-011 SHALL have port mode, output, 2 bits: current mode.

Function
REQ-012 Each button SHALL pass through a 2-FF synchronizer and then a debouncer.
REQ-013 The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch restarts the count.
REQ-014 A debounced 1->0 transition SHALL produce a one-cycle press event; release SHALL produce no event.
REQ-015 Prescaler: SHALL count 0..CLK_DIV-1 and wrap to 0; tick=1 for one cycle when it wraps; while paused it SHALL hold its value and tick SHALL stay 0.
REQ-016 Mode 0 (binary up): on tick, value+1 mod 2^WIDTH.
REQ-017 Mode 1 (binary down): on tick, value-1 mod 2^WIDTH (0 -> 2^WIDTH-1).
REQ-018 Mode 2 (gray): on tick, internal binary value+1 mod 2^WIDTH; pattern = bin ^ (bin >> 1).
REQ-019 Mode 3 (bounce): pattern = 1 << pos; on tick pos moves one step in the current direction; the direction reverses when pos reaches WIDTH-1 or 0, so both ends are shown exactly once per sweep.
REQ-020 led SHALL equal the pattern, or ~pattern when LED_ACTIVE_LOW=1, registered one cycle after the state update; in mode 0, tick in cycle N is visible on led in cycle N+1.
REQ-021 A mode press SHALL set mode to (mode+1) mod 4 (3 -> 0), and SHALL clear the value, the prescaler, pos, and direction (direction = up).
REQ-022 When a mode press and a tick occur in the same cycle, the mode press SHALL win: no step is applied and the tick is suppressed.
REQ-023 A pause press SHALL toggle paused; the pattern and mode SHALL be held while paused; mode presses SHALL still be accepted while paused, and paused SHALL stay set.
REQ-024 Simultaneous mode and pause presses SHALL both take effect in the same cycle.

Reset
REQ-025 With rst_n=0 at a clk edge, the block SHALL set mode=0, value=0, pos=0, direction=up, paused=0, prescaler=0, and tick=0.
REQ-026 During reset, led SHALL be all-off: all 1s when LED_ACTIVE_LOW=1, else all 0s.
REQ-027 During reset, the debouncer states SHALL be set to 1 (released) and the debounce counters to 0, so no press event is generated from reset release.
REQ-028 Reset asserted mid-operation in any mode or paused state SHALL take effect on that edge, with no pending step or press applied afterwards.

Verification (WIDTH=6, CLK_DIV=4, DEBOUNCE_CYCLES=3, LED_ACTIVE_LOW=0 unless stated)
REQ-029 Reset release, no buttons -> led=0; tick every 4th cycle; led = 1,2,3,...,63,0 (wrap after 64 ticks).
REQ-030 One clean mode press -> mode=1, led=0; at the next tick led=63, then 62.
REQ-031 Two more mode presses (mode 3) -> led sequence 1,2,4,8,16,32,16,8,4,2,1,2; mode press at the tick cycle -> no step, mode 3->0, led=0.
REQ-032 Mode 2 -> led sequence 0,1,3,2,6,7,5,4; a mode_btn glitch low for 2 cycles -> ignored, no mode change.
REQ-033 Pause press in mode 0 at led=5 -> led stays 5 and tick stays 0 for 40 cycles; a second press resumes with led=6 at the 4th cycle after resume.
REQ-034 LED_ACTIVE_LOW=1, mode 3, rst_n low for 1 cycle -> next cycle led=6'b111111, mode=0, tick=0; then led=~1 after 4 cycles.

Source files
------------

// File: rtl/led_pattern_counter.sv
// LED pattern counter.
// Two debounced push-buttons (mode, pause) drive a stepping pattern shown on
// a row of LEDs. A prescaler produces a step strobe every CLK_DIV cycles.
// The pattern is a binary up count, a binary down count, a Gray count, or a
// single lit LED bouncing end to end. Each button is synchronised with two
// flops and then debounced before its press event is used.

// Button conditioner: 2-FF synchronizer followed by a counting debouncer.
// press is high for exactly one cycle, on the edge where the debounced level
// falls from released (1) to pressed (0). Releases produce no event.
module led_pattern_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] count;
    logic             accept;

    // Bring the asynchronous button into the clk domain.
    // NOTE: every flop, synchronizer included, is cleared by the synchronous
    // reset so a released (high) button is seen right after reset and no
    // spurious edge is debounced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make sync_2 take the old sync_1,
            // giving a true two-stage chain regardless of statement order.
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // The synchronized level has differed for DEBOUNCE_CYCLES cycles in a row.
    assign accept = (sync_2 != level) && (count == CNT_LAST);
    // Only the released-to-pressed transition is an event.
    assign press  = accept && level;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync_2 == level) begin
            count <= '0;
        end else if (accept) begin
            level <= sync_2;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// Top level: prescaler, pattern state, mode/pause control and LED register.
module led_pattern_counter #(
    parameter int WIDTH           = 6,
    parameter int CLK_DIV         = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_btn,
    input  logic             pause_btn,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic [1:0]       mode
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int POS_W   = $clog2(WIDTH);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   LED_OFF    = LED_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    mode_t              mode_q;
    logic               paused;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   value;
    logic [POS_W-1:0]   pos;
    logic               dir_down;

    logic               mode_press;
    logic               pause_press;
    logic               wrap;
    logic               step;
    logic [POS_W-1:0]   pos_next;
    logic [WIDTH-1:0]   pattern;

    led_pattern_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (mode_btn),
        .press(mode_press)
    );

    led_pattern_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (pause_btn),
        .press(pause_press)
    );

    // A step is due when the running prescaler wraps; a mode press in the
    // same cycle takes priority and swallows the step.
    assign wrap = !paused && (presc == PRESC_LAST);
    assign step = wrap && !mode_press;

    // Prescaler and registered step strobe; frozen while paused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= step;
            if (mode_press || wrap) begin
                presc <= '0;
            end else if (!paused) begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    // Mode advance and pause toggle; both presses may land in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_UP;
            paused <= 1'b0;
        end else begin
            if (mode_press) begin
                mode_q <= mode_t'(mode_q + 2'd1);
            end
            if (pause_press) begin
                paused <= !paused;
            end
        end
    end

    // Next bounce position in the current direction.
    always_comb begin
        pos_next = dir_down ? (pos - POS_W'(1)) : (pos + POS_W'(1));
    end

    // Pattern state: counter value for the counting modes, position and
    // direction for bounce. A mode press restarts everything from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || mode_press) begin
            value    <= '0;
            pos      <= '0;
            dir_down <= 1'b0;
        end else if (step) begin
            unique case (mode_q)
                MODE_UP,
                MODE_GRAY:   value <= value + WIDTH'(1);
                MODE_DOWN:   value <= value - WIDTH'(1);
                MODE_BOUNCE: begin
                    pos <= pos_next;
                    // Turn around on reaching either end so each end is
                    // shown once per sweep.
                    if (pos_next == POS_LAST) begin
                        dir_down <= 1'b1;
                    end else if (pos_next == '0) begin
                        dir_down <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Decode the displayed pattern from the current state.
    always_comb begin
        // NOTE: a default before the case guarantees pattern is assigned on
        // every path, so no latch can be inferred.
        pattern = '0;
        unique case (mode_q)
            MODE_UP,
            MODE_DOWN:   pattern = value;
            MODE_GRAY:   pattern = value ^ (value >> 1);
            MODE_BOUNCE: pattern = WIDTH'(1) << pos;
        endcase
    end

    // LED drive register: one cycle behind the pattern state, dark in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led <= LED_OFF;
        end else begin
            led <= LED_ACTIVE_LOW ? ~pattern : pattern;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Testbench for led_pattern_counter.
// Two instances (active-high and active-low LEDs) share all inputs. A
// behavioural model derives the expected outputs from tick counts and press
// events; a compare process checks both instances on every falling edge.
// Directed sections pin the model with hand-computed literal values, then a
// randomized section drives both buttons and occasional resets.
module tb_led_pattern_counter;

    localparam int W      = 6;
    localparam int DIV    = 4;
    localparam int DB     = 3;
    localparam int PERIOD = 2 * (W - 1);
    localparam logic [63:0] MASK = (64'd1 << DB) - 64'd1;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         mode_btn  = 1'b1;
    logic         pause_btn = 1'b1;
    logic [W-1:0] led;
    logic [W-1:0] led_n;
    logic         tick;
    logic         tick_n;
    logic [1:0]   mode;
    logic [1:0]   mode_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_counter #(
        .WIDTH(W), .CLK_DIV(DIV), .DEBOUNCE_CYCLES(DB), .LED_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .pause_btn(pause_btn),
        .led(led), .tick(tick), .mode(mode)
    );

    led_pattern_counter #(
        .WIDTH(W), .CLK_DIV(DIV), .DEBOUNCE_CYCLES(DB), .LED_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .pause_btn(pause_btn),
        .led(led_n), .tick(tick_n), .mode(mode_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic budget_expired(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: awaited event not seen within its cycle budget at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int           m_mode;
    int           m_n;       // ticks since the last clear
    int           m_phase;   // unpaused cycles since the last clear
    bit           m_paused;
    bit           m_tick;
    bit           m_off;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_pat;
    bit           s1[2];
    bit           s2[2];
    bit           lvl[2];
    logic [63:0]  hist[2];
    int           nsince[2];

    // Pattern after n steps from a cleared start in mode md.
    function automatic logic [W-1:0] model_pattern(input int md, input int n);
        int v;
        int p;
        v = n % (1 << W);
        p = n % PERIOD;
        case (md)
            0:       return W'(v);
            1:       return W'(((1 << W) - v) % (1 << W));
            2:       return W'(v ^ (v >> 1));
            default: return W'(1) << ((p < W) ? p : PERIOD - p);
        endcase
    endfunction

    always @(posedge clk) begin
        bit raw[2];
        bit press[2];
        bit seen;
        raw[0] = mode_btn;
        raw[1] = pause_btn;
        if (!rst_n) begin
            m_mode = 0; m_n = 0; m_phase = 0;
            m_paused = 1'b0; m_tick = 1'b0; m_off = 1'b1; m_valid = 1'b1;
            for (int b = 0; b < 2; b++) begin
                s1[b] = 1'b1; s2[b] = 1'b1; lvl[b] = 1'b1;
                hist[b] = '0; nsince[b] = 0;
            end
        end else begin
            m_off = 1'b0;
            m_pat = model_pattern(m_mode, m_n);
            for (int b = 0; b < 2; b++) begin
                seen = s2[b];
                s2[b] = s1[b];
                s1[b] = raw[b];
                hist[b] = {hist[b][62:0], seen};
                nsince[b]++;
                press[b] = 1'b0;
                // Accept a change once the last DB samples since the previous
                // change all disagree with the debounced level.
                if (nsince[b] >= DB && ((hist[b] & MASK) == (lvl[b] ? 64'd0 : MASK))) begin
                    lvl[b] = ~lvl[b];
                    nsince[b] = 0;
                    press[b] = !lvl[b];
                end
            end
            if (press[0]) begin
                m_mode = (m_mode + 1) % 4;
                m_n = 0; m_phase = 0; m_tick = 1'b0;
            end else if (!m_paused) begin
                m_phase++;
                m_tick = (m_phase % DIV == 0);
                if (m_tick) m_n++;
            end else begin
                m_tick = 1'b0;
            end
            if (press[1]) m_paused = !m_paused;
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [W-1:0] exp_led;
            exp_led = m_off ? '0 : m_pat;
            check("model_active_high", {led, tick, mode}, {exp_led, m_tick, 2'(m_mode)});
            check("model_active_low", {led_n, tick_n, mode_n}, {~exp_led, m_tick, 2'(m_mode)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tick !== 1'b1 && k < 4 * DIV);
        if (tick !== 1'b1) budget_expired("wait_tick");
    endtask

    // Hold mode_btn low until the mode output reaches target.
    task automatic press_mode(input int target);
        int k;
        mode_btn = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mode !== 2'(target) && k < 12);
        if (mode !== 2'(target)) budget_expired("press_mode");
    endtask

    task automatic check_ticks(input string name, input int exp_leds[]);
        int k;
        foreach (exp_leds[i]) begin
            wait_tick(k);
            cycles(1);
            check(name, led, exp_leds[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bit found;
        int m_hold;
        int p_hold;

        // Reset state
        cycles(3);
        check("rst_led", led, 0);
        check("rst_led_active_low", led_n, 6'h3F);
        check("rst_tick", tick, 0);
        check("rst_mode", mode, 0);
        rst_n = 1'b1;

        // Binary up: a tick every DIV cycles, wrapping after 64 steps
        for (int i = 1; i <= 64; i++) begin
            wait_tick(k);
            check("tick_gap", k, (i == 1) ? DIV : DIV - 1);
            cycles(1);
            check("up_seq", led, i % 64);
        end

        // Mode 1: clear, then 63, 62
        press_mode(1);
        cycles(1);
        check("down_clear", led, 0);
        mode_btn = 1'b1;
        check_ticks("down_seq", '{63, 62});

        // Mode 3: bounce sweep
        press_mode(2);
        mode_btn = 1'b1;
        cycles(6);
        press_mode(3);
        cycles(1);
        check("bounce_clear", led, 1);
        mode_btn = 1'b1;
        check_ticks("bounce_seq", '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2});

        // Mode press landing on the wrap edge: no step, mode 3 -> 0
        cycles(2);
        press_mode(0);
        check("press_beats_tick", tick, 0);
        cycles(1);
        check("press_clear_up", led, 0);
        mode_btn = 1'b1;
        cycles(6);

        // Mode 2: Gray sequence, then a 2-cycle glitch is ignored
        press_mode(1);
        mode_btn = 1'b1;
        cycles(6);
        press_mode(2);
        cycles(1);
        check("gray_clear", led, 0);
        mode_btn = 1'b1;
        check_ticks("gray_seq", '{1, 3, 2, 6, 7, 5, 4});
        mode_btn = 1'b0;
        cycles(2);
        mode_btn = 1'b1;
        cycles(10);
        check("glitch_ignored", mode, 2);

        // Back to mode 0
        press_mode(3);
        mode_btn = 1'b1;
        cycles(6);
        press_mode(0);
        mode_btn = 1'b1;
        cycles(6);

        // Pause at led=5, hold 40 cycles, resume to 6
        found = 1'b0;
        for (int i = 0; i < 70 && !found; i++) begin
            wait_tick(k);
            cycles(1);
            if (led == 4) found = 1'b1;
        end
        if (!found) budget_expired("find_led_4");
        pause_btn = 1'b0;
        cycles(6);
        pause_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check("paused_hold", {led, tick}, {6'd5, 1'b0});
            cycles(1);
        end
        pause_btn = 1'b0;
        wait_tick(k);
        cycles(1);
        check("resume_step", led, 6);
        pause_btn = 1'b1;
        cycles(6);

        // Simultaneous mode and pause presses: mode 1, cleared and paused
        pause_btn = 1'b0;
        press_mode(1);
        cycles(1);
        mode_btn = 1'b1;
        pause_btn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("dual_press_paused", {led, tick}, {6'd0, 1'b0});
            cycles(1);
        end
        pause_btn = 1'b0;
        wait_tick(k);
        cycles(1);
        check("dual_press_resume", led, 63);
        pause_btn = 1'b1;
        cycles(6);

        // Mode press while paused: mode advances, pause persists
        pause_btn = 1'b0;
        cycles(6);
        pause_btn = 1'b1;
        cycles(6);
        press_mode(2);
        cycles(1);
        mode_btn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("mode_while_paused", {led, tick}, {6'd0, 1'b0});
            cycles(1);
        end
        pause_btn = 1'b0;
        cycles(6);
        pause_btn = 1'b1;
        cycles(6);

        // Reset mid-operation in mode 3 with a mode press half debounced
        press_mode(3);
        mode_btn = 1'b1;
        cycles(6);
        wait_tick(k);
        mode_btn = 1'b0;
        cycles(2);
        rst_n = 1'b0;
        cycles(1);
        check("midrst_led_active_low", led_n, 6'h3F);
        check("midrst_mode", mode, 0);
        check("midrst_tick", tick, 0);
        rst_n = 1'b1;
        mode_btn = 1'b1;
        wait_tick(k);
        check("midrst_tick_latency", k, DIV);
        cycles(1);
        check("midrst_first_step", led_n, 6'h3E);
        check("midrst_no_pending_press", mode, 0);

        // Randomized buttons and occasional resets
        m_hold = 0;
        p_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_hold == 0) begin
                mode_btn = ($urandom_range(0, 2) == 0);
                m_hold = mode_btn ? $urandom_range(4, 40) : $urandom_range(1, 6);
            end
            if (p_hold == 0) begin
                pause_btn = ($urandom_range(0, 4) != 0);
                p_hold = pause_btn ? $urandom_range(20, 120) : $urandom_range(1, 6);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            m_hold--;
            p_hold--;
            cycles(1);
        end
        rst_n = 1'b1;
        mode_btn = 1'b1;
        pause_btn = 1'b1;
        cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
